// File: rtl/mem_stage_access_unit.sv
// Memory-stage access controller: drives the 16-bit data memory port for scalar and
// 128-bit vector loads/stores, splitting vector accesses into one 16-bit beat per cycle.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// S_IDLE   | sample requests; scalar store, or first beat of other ops
// S_SLOAD  | scalar read data arriving; capture and complete
// S_VSTORE | writing vector lanes 1..LANES-1 from the latched data
// S_VLOAD  | reading lanes 1..LANES-1, capturing the previous lane
// S_VDRAIN | capture last lane and publish the full vector
module mem_stage_access_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        store_scalar,
  input  logic                        store_vector,
  input  logic                        load_scalar,
  input  logic                        load_vector,
  input  logic [ADDR_WIDTH-1:0]       addr_in,
  input  logic [DATA_WIDTH-1:0]       store_data_in,
  input  logic [LANES*DATA_WIDTH-1:0] vector_store_data_in,
  output logic [ADDR_WIDTH-1:0]       dmem_addr,
  output logic [DATA_WIDTH-1:0]       dmem_wdata,
  output logic                        dmem_we,
  output logic                        dmem_re,
  input  logic [DATA_WIDTH-1:0]       dmem_rdata,
  output logic                        stall,
  output logic                        done,
  output logic [DATA_WIDTH-1:0]       load_data_out,
  output logic [LANES*DATA_WIDTH-1:0] vector_load_data_out
);

  localparam int VEC_W  = LANES * DATA_WIDTH;
  localparam int SHD_W  = VEC_W - DATA_WIDTH;
  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SLOAD  = 3'd1,
    S_VSTORE = 3'd2,
    S_VLOAD  = 3'd3,
    S_VDRAIN = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [BEAT_W-1:0]       r_beat, w_beat_nxt, w_prev_beat;
  logic [ADDR_WIDTH-1:0]   r_base, w_lane_addr;
  logic [VEC_W-1:0]        r_vdata, r_vload_data;
  // The last lane never lands in the shadow; it goes straight to the output on drain.
  logic [SHD_W-1:0]        r_shadow;
  logic [DATA_WIDTH-1:0]   r_load_data, w_lane_wdata;
  logic                    w_latch_base, w_latch_vdata;
  logic                    w_cap_scalar, w_cap_lane, w_cap_final;
  logic                    w_we, w_re, w_stall, w_done;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;

  assign w_lane_addr  = r_base + ADDR_WIDTH'(r_beat);
  assign w_lane_wdata = r_vdata[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH];
  assign w_prev_beat  = r_beat - BEAT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_we          = 1'b0;
    w_re          = 1'b0;
    w_addr        = '0;
    w_wdata       = '0;
    w_stall       = 1'b0;
    w_done        = 1'b0;
    w_latch_base  = 1'b0;
    w_latch_vdata = 1'b0;
    w_cap_scalar  = 1'b0;
    w_cap_lane    = 1'b0;
    w_cap_final   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (store_vector) begin
          w_we          = 1'b1;
          w_addr        = addr_in;
          w_wdata       = vector_store_data_in[DATA_WIDTH-1:0];
          w_stall       = 1'b1;
          w_latch_base  = 1'b1;
          w_latch_vdata = 1'b1;
          w_beat_nxt    = BEAT_W'(1);
          w_state_nxt   = S_VSTORE;
        end else if (load_vector) begin
          w_re         = 1'b1;
          w_addr       = addr_in;
          w_stall      = 1'b1;
          w_latch_base = 1'b1;
          w_beat_nxt   = BEAT_W'(1);
          w_state_nxt  = S_VLOAD;
        end else if (store_scalar) begin
          w_we    = 1'b1;
          w_addr  = addr_in;
          w_wdata = store_data_in;
        end else if (load_scalar) begin
          w_re        = 1'b1;
          w_addr      = addr_in;
          w_stall     = 1'b1;
          w_state_nxt = S_SLOAD;
        end
      end
      S_SLOAD: begin
        w_cap_scalar = 1'b1;
        w_done       = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      S_VSTORE: begin
        w_we    = 1'b1;
        w_addr  = w_lane_addr;
        w_wdata = w_lane_wdata;
        if (r_beat == LAST_BEAT) begin
          w_done      = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall    = 1'b1;
          w_beat_nxt = r_beat + BEAT_W'(1);
        end
      end
      S_VLOAD: begin
        w_re       = 1'b1;
        w_addr     = w_lane_addr;
        w_stall    = 1'b1;
        w_cap_lane = 1'b1;
        if (r_beat == LAST_BEAT) begin
          w_beat_nxt  = '0;
          w_state_nxt = S_VDRAIN;
        end else begin
          w_beat_nxt = r_beat + BEAT_W'(1);
        end
      end
      S_VDRAIN: begin
        w_cap_final = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end
    endcase

    // Reset must silence the memory port in the same cycle, not one edge later.
    if (reset) begin
      w_we    = 1'b0;
      w_re    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      w_stall = 1'b0;
      w_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_base       <= '0;
      r_vdata      <= '0;
      r_shadow     <= '0;
      r_load_data  <= '0;
      r_vload_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_latch_base)  r_base  <= addr_in;
      if (w_latch_vdata) r_vdata <= vector_store_data_in;
      if (w_cap_scalar)  r_load_data <= dmem_rdata;
      if (w_cap_lane)    r_shadow[int'(w_prev_beat)*DATA_WIDTH +: DATA_WIDTH] <= dmem_rdata;
      if (w_cap_final)   r_vload_data <= {dmem_rdata, r_shadow};
    end
  end

  assign dmem_we              = w_we;
  assign dmem_re              = w_re;
  assign dmem_addr            = w_addr;
  assign dmem_wdata           = w_wdata;
  assign stall                = w_stall;
  assign done                 = w_done;
  assign load_data_out        = r_load_data;
  assign vector_load_data_out = r_vload_data;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed scenarios plus random operations, each compared
// cycle by cycle against a transaction-level expectation built from the access rules.
module tb_mem_stage_access_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int L  = 8;
  localparam int VW = L * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          store_scalar, store_vector, load_scalar, load_vector;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] store_data_in;
  logic [VW-1:0] vector_store_data_in;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we, dmem_re;
  logic [DW-1:0] dmem_rdata = '0;
  logic          stall, done;
  logic [DW-1:0] load_data_out;
  logic [VW-1:0] vector_load_data_out;

  always #5 clk = ~clk;

  mem_stage_access_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .store_scalar         (store_scalar),
    .store_vector         (store_vector),
    .load_scalar          (load_scalar),
    .load_vector          (load_vector),
    .addr_in              (addr_in),
    .store_data_in        (store_data_in),
    .vector_store_data_in (vector_store_data_in),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_we              (dmem_we),
    .dmem_re              (dmem_re),
    .dmem_rdata           (dmem_rdata),
    .stall                (stall),
    .done                 (done),
    .load_data_out        (load_data_out),
    .vector_load_data_out (vector_load_data_out)
  );

  // Memory seen by the DUT, and an independent reference image of what it should hold.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic          p_we = 1'b0, p_re = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;

  always @(negedge clk) begin
    p_we    = dmem_we;
    p_re    = dmem_re;
    p_addr  = dmem_addr;
    p_wdata = dmem_wdata;
  end

  always @(posedge clk) begin
    if (p_re) dmem_rdata <= mem[p_addr];
    if (p_we) mem[p_addr] <= p_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          we, re, stall, done;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cyc_t;

  cyc_t          exp_q[$];
  logic [DW-1:0] exp_ld;
  logic [VW-1:0] exp_vld;

  task automatic drive_idle();
    store_scalar = 1'b0; store_vector = 1'b0;
    load_scalar  = 1'b0; load_vector  = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobes"}, VW'({dmem_we, dmem_re, stall, done}), '0);
    check({tag, "_addr"},    VW'(dmem_addr), '0);
    check({tag, "_wdata"},   VW'(dmem_wdata), '0);
    check({tag, "_ld"},      VW'(load_data_out), '0);
    check({tag, "_vld"},     vector_load_data_out, '0);
  endtask

  // Called just after a posedge; returns just after the op's final posedge.
  task automatic run_op(input logic sv, input logic lv, input logic ss, input logic ls,
                        input logic [AW-1:0] a, input logic [DW-1:0] sd, input logic [VW-1:0] vd);
    cyc_t c;
    exp_q.delete();
    if (sv) begin
      for (int k = 0; k < L; k++) begin
        c.we = 1'b1; c.re = 1'b0;
        c.addr  = a + AW'(k);
        c.wdata = vd[k*DW +: DW];
        c.stall = (k < L - 1);
        c.done  = (k == L - 1);
        exp_q.push_back(c);
        ref_mem[c.addr] = c.wdata;
      end
    end else if (lv) begin
      for (int k = 0; k < L; k++) begin
        c.we = 1'b0; c.re = 1'b1; c.stall = 1'b1; c.done = 1'b0;
        c.addr = a + AW'(k); c.wdata = '0;
        exp_q.push_back(c);
        exp_vld[k*DW +: DW] = ref_mem[c.addr];
      end
      c.we = 1'b0; c.re = 1'b0; c.stall = 1'b0; c.done = 1'b1; c.addr = '0; c.wdata = '0;
      exp_q.push_back(c);
    end else if (ss) begin
      c.we = 1'b1; c.re = 1'b0; c.stall = 1'b0; c.done = 1'b0; c.addr = a; c.wdata = sd;
      exp_q.push_back(c);
      ref_mem[a] = sd;
    end else if (ls) begin
      c.we = 1'b0; c.re = 1'b1; c.stall = 1'b1; c.done = 1'b0; c.addr = a; c.wdata = '0;
      exp_q.push_back(c);
      c.re = 1'b0; c.stall = 1'b0; c.done = 1'b1; c.addr = '0;
      exp_q.push_back(c);
      exp_ld = ref_mem[a];
    end else begin
      c.we = 1'b0; c.re = 1'b0; c.stall = 1'b0; c.done = 1'b0; c.addr = '0; c.wdata = '0;
      exp_q.push_back(c);
    end

    store_vector = sv; load_vector = lv; store_scalar = ss; load_scalar = ls;
    addr_in = a; store_data_in = sd; vector_store_data_in = vd;

    foreach (exp_q[k]) begin
      @(negedge clk);
      check("strobes_we_re_stall_done", VW'({dmem_we, dmem_re, stall, done}),
            VW'({exp_q[k].we, exp_q[k].re, exp_q[k].stall, exp_q[k].done}));
      if (exp_q[k].we || exp_q[k].re) check("dmem_addr", VW'(dmem_addr), VW'(exp_q[k].addr));
      if (exp_q[k].we) check("dmem_wdata", VW'(dmem_wdata), VW'(exp_q[k].wdata));
      @(posedge clk); #1;
    end
    drive_idle();
    check("load_data_out", VW'(load_data_out), VW'(exp_ld));
    check("vector_load_data_out", vector_load_data_out, exp_vld);
  endtask

  logic [VW-1:0] vd;
  logic [AW-1:0] ra;
  logic [3:0]    req;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    drive_idle();
    addr_in = '0; store_data_in = '0; vector_store_data_in = '0;
    exp_ld = '0; exp_vld = '0;

    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");
    @(posedge clk); #1;

    // Scalar store then scalar load.
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, '0);
    check("mem_0010", VW'(mem[16'h0010]), VW'(16'hBEEF));
    mem[16'h0020] = 16'h1234; ref_mem[16'h0020] = 16'h1234;
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, '0, '0);
    check("scalar_load_value", VW'(load_data_out), VW'(16'h1234));

    // Vector store of lanes 0..7 at 0x0100.
    for (int k = 0; k < L; k++) vd[k*DW +: DW] = DW'(k);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, '0, vd);

    // Wrapping vector load at 0xFFFC.
    for (int k = 0; k < L; k++) begin
      mem[16'hFFFC + AW'(k)]     = DW'(16'hA0 + k);
      ref_mem[16'hFFFC + AW'(k)] = DW'(16'hA0 + k);
      vd[k*DW +: DW] = DW'(16'hA0 + k);
    end
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFC, '0, '0);
    check("wrap_vload_value", vector_load_data_out, vd);

    // Priority: vector store beats scalar load, then scalar store with no bubble.
    vd = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h5555, vd);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0300, 16'hC0DE, '0);

    // Reset while a vector load is at beat 4.
    load_vector = 1'b1; addr_in = 16'h0400;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_vload_re", VW'({dmem_re, dmem_we, stall}), VW'(3'b101));
      check("abort_vload_addr", VW'(dmem_addr), VW'(16'h0400 + k));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    check("abort_in_reset", VW'({dmem_we, dmem_re, stall, done, dmem_addr, dmem_wdata}), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ld = '0; exp_vld = '0;
    @(negedge clk);
    check_outputs_zero("abort_after");
    @(posedge clk); #1;
    mem[16'h0500] = 16'h7E57; ref_mem[16'h0500] = 16'h7E57;
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 16'h0500, '0, '0);

    // Random operation mix, addresses biased toward the wrap boundary.
    for (int n = 0; n < 300; n++) begin
      req = 4'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'(16'hFFF8 + $urandom_range(0, 7));
      vd  = {$urandom, $urandom, $urandom, $urandom};
      run_op(req[3], req[2], req[1], req[0], ra, DW'($urandom), vd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_unit.md
# mem_stage_access_unit

Memory-stage access controller that consumes the execute/memory pipeline register outputs and drives the 16-bit data memory port. Scalar stores complete in one cycle. Scalar loads and 128-bit vector loads/stores are sequenced as 16-bit beats, and the unit raises a pipeline stall while a sequence is in flight. Load results go to the memory/writeback boundary as registered data plus a one-cycle done pulse.

## Interface
- ADDR_WIDTH, 16, data memory word-address width
- DATA_WIDTH, 16, data memory word width
- LANES, 8, 16-bit lanes per vector (vector width = LANES*DATA_WIDTH = 128)

- clk  input  1  clock
- reset  input  1  synchronous, active-high
- store_scalar  input  1  scalar store request (write enable A of the memory stage)
- store_vector  input  1  vector store request (write enable B of the memory stage)
- load_scalar  input  1  scalar load request
- load_vector  input  1  vector load request
- addr_in  input  ADDR_WIDTH  base address (ALU result)
- store_data_in  input  DATA_WIDTH  scalar store data (srcB)
- vector_store_data_in  input  LANES*DATA_WIDTH  vector store data (vector srcB)
- dmem_addr  output  ADDR_WIDTH  memory address
- dmem_wdata  output  DATA_WIDTH  memory write data
- dmem_we  output  1  memory write strobe
- dmem_re  output  1  memory read strobe
- dmem_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after dmem_re
- stall  output  1  hold upstream pipeline registers
- done  output  1  one-cycle pulse: load result valid / vector store finished
- load_data_out  output  DATA_WIDTH  registered scalar load result
- vector_load_data_out  output  LANES*DATA_WIDTH  registered vector load result

## Operation
- States: IDLE, SLOAD, VSTORE, VLOAD, VDRAIN. Beat counter `beat` is 3 bits and counts 0..LANES-1.
- Lane mapping: lane i ↔ address base+i ↔ bits [16i+15:16i]. Address addition is modulo 2^ADDR_WIDTH, so 0xFFFF+1 wraps to 0x0000.
- Requests are sampled only in IDLE. If more than one is asserted, priority is store_vector > load_vector > store_scalar > load_scalar; the lower-priority requests are dropped.
- IDLE behaviour, by request:
  - store_scalar: dmem_we=1, dmem_addr=addr_in, dmem_wdata=store_data_in; stall=0; remain IDLE; no done.
  - load_scalar: dmem_re=1, dmem_addr=addr_in, stall=1 → SLOAD.
  - store_vector: issue lane 0 from the inputs directly; latch base address and the 128-bit data; stall=1; beat←1 → VSTORE.
  - load_vector: dmem_re=1 at base; latch base; stall=1; beat←1 → VLOAD.
- SLOAD: load_data_out←dmem_rdata, done=1, stall=0 → IDLE.
- VSTORE: write lane `beat` at base+beat from the latched data. stall=1 while beat<LANES-1. On beat=LANES-1: stall=0, done=1 → IDLE.
- VLOAD: read base+beat and capture dmem_rdata into lane beat-1 of an internal shadow. stall=1. After beat=LANES-1 → VDRAIN.
- VDRAIN: capture lane LANES-1, then copy the complete shadow into vector_load_data_out in the same edge; done=1, stall=0 → IDLE.
- vector_load_data_out and load_data_out change only on a completing edge. Partial lanes are never visible.
- dmem_we/dmem_re are never both 1. Both are 0 in any cycle without an access and whenever reset=1.

## Timing
- Reset (synchronous): state=IDLE, beat=0. stall, done, dmem_we, dmem_re, dmem_addr, dmem_wdata, load_data_out and vector_load_data_out all read 0.
- Reset mid-sequence aborts with no further memory strobes. Writes already issued stay in memory, and the result registers clear to 0.
- Scalar store: 1 cycle, 0 stall cycles.
- Scalar load: 2 cycles, 1 stall cycle. Data and done appear in cycle 2.
- Vector store: 8 write cycles, 7 stall cycles. done is asserted in the 8th cycle.
- Vector load: 9 cycles (8 reads + drain), 8 stall cycles. Data and done appear in cycle 9.
- The cycle after done (stall=0) is IDLE and samples the next instruction. Back-to-back operations therefore have no bubble.
- stall is combinational from state/requests, so upstream registers must gate their enable with it in the same cycle.

## Test plan
- Scalar store at addr 0x0010, data 0xBEEF → one cycle with dmem_we=1, addr 0x0010, wdata 0xBEEF; stall never asserted; done stays 0.
- Scalar load at 0x0020 with memory[0x20]=0x1234 → stall=1 for 1 cycle, then done=1 and load_data_out=0x1234.
- Vector store at base 0x0100 with data 0x0007_0006_0005_0004_0003_0002_0001_0000 → 8 writes to 0x0100..0x0107 with wdata 0..7; stall high for 7 cycles; done in cycle 8.
- Vector load at base 0xFFFC (wraps) with memory words 0xA0..0xA7 → reads 0xFFFC..0xFFFF then 0x0000..0x0003; vector_load_data_out lanes 0..7 = 0xA0..0xA7; done in cycle 9; stall 8 cycles.
- store_vector and load_scalar asserted together → only the vector store executes and dmem_re is never asserted. Follow it immediately with a scalar store and confirm the store issues in the cycle after done.
- Reset at beat 4 of a vector load → next cycle all outputs are 0 and IDLE. A subsequent scalar load completes normally.
